vproc_vrot_unit: RTL

- Multi-cycle vector byte-rotation unit for the custom SPHINCS+ vector instruction path.
- Rotates the first vl bytes of a VREG_W-bit operand by an arbitrary byte amount, in either direction. Bytes at or above vl follow the tail rule.
- Uses an iterative logarithmic rotator: log2 stages, STAGES_PER_CYCLE applied per clock.
- Sits between operand read and the custom-unit result writeback; valid/ready on both sides.

---
 rtl/vproc_custom_pkg.sv | 38 +++
 rtl/vproc_vrot_stage.sv | 58 +++++
 rtl/vproc_vrot_unit.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/vproc_custom_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_custom (package)
//  Description : Shared types and constants for the custom SPHINCS+ vector
//                units. Holds the byte-rotation unit's direction and state
//                encodings, its request bundle and its default stage count.
//                The constants below describe the default 128-bit register
//                configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
package vproc_custom;

    localparam int unsigned VROT_VREG_W = 128;
    localparam int unsigned VROT_LOG_B  = $clog2(VROT_VREG_W / 8);
    localparam int unsigned VROT_AMT_W  = VROT_LOG_B + 2;
    localparam int unsigned VROT_VL_W   = VROT_LOG_B + 1;

    typedef enum logic {
        VROT_DOWN = 1'b0,
        VROT_UP   = 1'b1
    } vrot_dir_e;

    typedef enum logic [1:0] {
        VROT_IDLE   = 2'd0,
        VROT_REDUCE = 2'd1,
        VROT_ROTATE = 2'd2,
        VROT_DONE   = 2'd3
    } vrot_state_e;

    typedef struct packed {
        logic [VROT_AMT_W-1:0] amount;
        logic [VROT_VL_W-1:0]  vl;
        vrot_dir_e             dir;
        logic [4:0]            tag;
    } vrot_req_t;

endpackage
`default_nettype wire

// File: rtl/vproc_vrot_stage.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_vrot_stage
//  Description : One combinational step of the windowed logarithmic rotator.
//                When enabled, every byte i < vl takes byte
//                (i + 2^stage) mod vl; bytes at or above vl pass through.
//                The modulo is a single conditional subtract, which is exact
//                because the caller only enables stages with 2^stage < vl.
//  Ports       : i_data  - vector in          o_data - vector out
//                i_en    - apply this stage   i_vl   - active length (bytes)
//                i_stage - stage index s (rotate by 2^s bytes)
//  Revision    : 1.0 - initial release
// ============================================================================
module vproc_vrot_stage
    import vproc_custom::*;
#(
    parameter int unsigned VREG_W = 128,
    parameter int unsigned VL_W   = $clog2(VREG_W / 8) + 1,
    parameter int unsigned STG_W  = 3
) (
    input  logic [VREG_W-1:0] i_data,
    input  logic              i_en,
    input  logic [VL_W-1:0]   i_vl,
    input  logic [STG_W-1:0]  i_stage,
    output logic [VREG_W-1:0] o_data
);

    localparam int unsigned c_NUM_BYTES = VREG_W / 8;
    localparam int unsigned c_LOG_B     = $clog2(c_NUM_BYTES);
    localparam int unsigned c_IDX_W     = c_LOG_B + 2;

    logic [c_IDX_W-1:0] w_shift;
    logic [c_IDX_W-1:0] w_vl_ext;

    assign w_shift  = c_IDX_W'(1) << i_stage;
    assign w_vl_ext = c_IDX_W'(i_vl);

    genvar i;
    generate
        for (i = 0; i < int'(c_NUM_BYTES); i++) begin : g_byte
            logic [c_IDX_W-1:0] w_sum;
            logic [c_LOG_B-1:0] w_sel;
            logic               w_active;

            assign w_sum    = c_IDX_W'(i) + w_shift;
            // For active lanes the wrapped source index is < vl <= bytes,
            // so it always fits in LOG_B bits.
            assign w_sel    = (w_sum >= w_vl_ext) ? c_LOG_B'(w_sum - w_vl_ext)
                                                  : c_LOG_B'(w_sum);
            assign w_active = i_en && (c_IDX_W'(i) < w_vl_ext);

            assign o_data[i*8 +: 8] = w_active ? i_data[{w_sel, 3'b000} +: 8]
                                               : i_data[i*8 +: 8];
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/vproc_vrot_unit.sv
`default_nettype none
// ============================================================================
//  Module      : vproc_vrot_unit
//  Description : Multi-cycle vector byte rotation. Rotates the first vl bytes
//                of the operand by an arbitrary byte amount, down
//                (out[i]=in[(i+r)%vl]) or up (out[i]=in[(i-r)%vl]). The
//                amount is first reduced modulo vl by repeated subtraction
//                (one subtract per cycle), then applied by an iterative
//                logarithmic rotator, STAGES_PER_CYCLE stages per clock.
//  Ports       : clk_i, sync_rst_ni (synchronous, active low)
//                in_valid_i/in_ready_o, in_data_i, in_amount_i, in_vl_i,
//                in_dir_i, in_tag_i                    - request side
//                out_valid_o/out_ready_i, out_data_o, out_tag_o - result side
//                busy_o                                - unit not idle
//  Options     : VPROC_VROT_TAIL_ZERO_EN - when defined, result bytes at or
//                above vl read as 0x00; otherwise they keep the source value.
//  Revision    : 1.0 - initial release
// ============================================================================
module vproc_vrot_unit
    import vproc_custom::*;
#(
    parameter int unsigned VREG_W           = 128,
    parameter int unsigned STAGES_PER_CYCLE = 1,
    parameter int unsigned AMT_W            = $clog2(VREG_W / 8) + 2,
    parameter int unsigned VL_W             = $clog2(VREG_W / 8) + 1
) (
    input  logic              clk_i,
    input  logic              sync_rst_ni,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [VREG_W-1:0] in_data_i,
    input  logic [AMT_W-1:0]  in_amount_i,
    input  logic [VL_W-1:0]   in_vl_i,
    input  logic              in_dir_i,
    input  logic [4:0]        in_tag_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [VREG_W-1:0] out_data_o,
    output logic [4:0]        out_tag_o,
    output logic              busy_o
);

    localparam int unsigned c_NUM_BYTES = VREG_W / 8;
    localparam int unsigned c_LOG_B     = $clog2(c_NUM_BYTES);
    // Wide enough to hold the stage counter after its final advance.
    localparam int unsigned c_K_W       = $clog2(c_LOG_B + STAGES_PER_CYCLE + 1);
    localparam logic [c_K_W-1:0] c_K_STEP = c_K_W'(STAGES_PER_CYCLE);
    localparam logic [c_K_W-1:0] c_K_LAST = c_K_W'(c_LOG_B);
    localparam logic [VL_W-1:0]  c_VL_MAX = VL_W'(c_NUM_BYTES);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    vrot_state_e       r_state;
    vrot_state_e       w_state_nxt;

    logic [VREG_W-1:0] r_data;
    logic [AMT_W-1:0]  r_amt;
    logic [VL_W-1:0]   r_vl;
    vrot_dir_e         r_dir;
    logic [4:0]        r_tag;
    logic [VL_W-1:0]   r_eff;
    logic [c_K_W-1:0]  r_k;

    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_busy;
    logic              w_accept;
    logic [VL_W-1:0]   w_vl_clamped;
    logic              w_amt_ge_vl;
    logic [VL_W-1:0]   w_amt_lo;
    logic [VL_W-1:0]   w_eff;
    logic [c_K_W-1:0]  w_k_nxt;

    assign w_accept     = in_valid_i && w_in_ready;
    assign w_vl_clamped = (in_vl_i > c_VL_MAX) ? c_VL_MAX : in_vl_i;
    assign w_amt_ge_vl  = (r_amt >= AMT_W'(r_vl));
    // Once amt < vl the residual amount fits the vl width.
    assign w_amt_lo     = r_amt[VL_W-1:0];
    // Rotating up by r equals rotating down by vl - r.
    assign w_eff        = (r_dir == VROT_UP) ? ((w_amt_lo == '0) ? '0 : (r_vl - w_amt_lo))
                                             : w_amt_lo;
    assign w_k_nxt      = r_k + c_K_STEP;

    // ------------------------------------------------------------------
    // Rotator stage chain: stage j of this cycle applies bit (k + j)
    // ------------------------------------------------------------------
    logic [VREG_W-1:0] w_chain [STAGES_PER_CYCLE+1];

    assign w_chain[0] = r_data;

    genvar j;
    generate
        for (j = 0; j < int'(STAGES_PER_CYCLE); j++) begin : g_stage
            logic [c_K_W-1:0] w_idx;
            logic             w_en;

            assign w_idx = r_k + c_K_W'(j);
            assign w_en  = (w_idx < c_K_LAST) && (|(r_eff & (VL_W'(1) << w_idx)));

            vproc_vrot_stage #(
                .VREG_W (VREG_W),
                .VL_W   (VL_W),
                .STG_W  (c_K_W)
            ) u_stage (
                .i_data  (w_chain[j]),
                .i_en    (w_en),
                .i_vl    (r_vl),
                .i_stage (w_idx),
                .o_data  (w_chain[j+1])
            );
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_state <= VROT_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            VROT_IDLE: begin
                w_in_ready = 1'b1;
                w_busy     = 1'b0;
                if (in_valid_i) begin
                    w_state_nxt = VROT_REDUCE;
                end
            end
            VROT_REDUCE: begin
                if (r_vl == '0) begin
                    w_state_nxt = VROT_DONE;
                end else if (!w_amt_ge_vl) begin
                    w_state_nxt = VROT_ROTATE;
                end
            end
            VROT_ROTATE: begin
                if (w_k_nxt >= c_K_LAST) begin
                    w_state_nxt = VROT_DONE;
                end
            end
            VROT_DONE: begin
                w_out_valid = 1'b1;
                if (out_ready_i) begin
                    w_state_nxt = VROT_IDLE;
                end
            end
            default: begin
                w_state_nxt = VROT_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!sync_rst_ni) begin
            r_data <= '0;
            r_amt  <= '0;
            r_vl   <= '0;
            r_dir  <= VROT_DOWN;
            r_tag  <= '0;
            r_eff  <= '0;
            r_k    <= '0;
        end else begin
            case (r_state)
                VROT_IDLE: begin
                    if (w_accept) begin
                        r_data <= in_data_i;
                        r_amt  <= in_amount_i;
                        r_vl   <= w_vl_clamped;
                        r_dir  <= vrot_dir_e'(in_dir_i);
                        r_tag  <= in_tag_i;
                    end
                end
                VROT_REDUCE: begin
                    if (r_vl != '0) begin
                        if (w_amt_ge_vl) begin
                            r_amt <= r_amt - AMT_W'(r_vl);
                        end else begin
                            r_eff <= w_eff;
                            r_k   <= '0;
                        end
                    end
                end
                VROT_ROTATE: begin
                    r_data <= w_chain[STAGES_PER_CYCLE];
                    r_k    <= w_k_nxt;
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready_o  = w_in_ready;
    assign out_valid_o = w_out_valid;
    assign busy_o      = w_busy;
    assign out_tag_o   = r_tag;

`ifdef VPROC_VROT_TAIL_ZERO_EN
    logic [VREG_W-1:0] w_tail_mask;

    genvar t;
    generate
        for (t = 0; t < int'(c_NUM_BYTES); t++) begin : g_tail
            assign w_tail_mask[t*8 +: 8] = (VL_W'(t) < r_vl) ? 8'hFF : 8'h00;
        end
    endgenerate

    assign out_data_o = r_data & w_tail_mask;
`else
    // Tail bytes are never touched by the rotator, so they already hold the
    // source bytes.
    assign out_data_o = r_data;
`endif

endmodule
`default_nettype wire
